// File: rtl/wb_bram_ctrl_if.sv
// Wishbone slave bus bundle for wb_bram_ctrl.
// Ports: wb_cyc_i/wb_stb_i/wb_we_i cycle, strobe and write enable; wb_adr_i byte address;
//        wb_dat_i/wb_sel_i write data and byte selects; wb_cti_i cycle type;
//        wb_dat_o/wb_ack_o/wb_err_o read data, acknowledge and error from the slave.
interface wb_bram_ctrl_if #(
   parameter int unsigned DATA_W = 32
) ();
   localparam int unsigned SEL_W = DATA_W / 8;

   logic              wb_cyc_i;
   logic              wb_stb_i;
   logic              wb_we_i;
   logic [31:0]       wb_adr_i;
   logic [DATA_W-1:0] wb_dat_i;
   logic [SEL_W-1:0]  wb_sel_i;
   logic [2:0]        wb_cti_i;
   logic [DATA_W-1:0] wb_dat_o;
   logic              wb_ack_o;
   logic              wb_err_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic/incrementing-burst slave in front of a synchronous block RAM.
// Ports: wb_clk_i clock; wb_rst_i async active-low reset; wb Wishbone slave bundle;
//        ram_en/ram_we/ram_addr/ram_wdata RAM request (combinational in the request cycle);
//        ram_rdata RAM read data, valid RD_LAT cycles after ram_en.
module wb_bram_ctrl #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned RD_LAT    = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   wb_bram_ctrl_if.slave       wb,
   output logic                ram_en,
   output logic [DATA_W/8-1:0] ram_we,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_wdata,
   input  logic [DATA_W-1:0]   ram_rdata
);
   localparam int unsigned SEL_W  = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(SEL_W);
   localparam int unsigned TAG_LO = OFF_W + ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE, S_WACK, S_RWAIT, S_RACK, S_WBURST, S_RBURST, S_ERR
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_ack;
   logic                r_err;
   logic [DATA_W-1:0]   r_dat;
   logic [ADDR_W-1:0]   r_addr;
   logic [RD_LAT-1:0]   r_pipe;

   logic                w_req;
   logic                w_hit;
   logic [ADDR_W-1:0]   w_waddr;
   logic                w_cti_inc;
   logic                w_cti_end;
   logic                w_rd_valid;
   logic                w_ack_nxt;
   logic                w_err_nxt;
   logic                w_issue;
   logic                w_flush;
   logic                w_capture;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic                w_unused;

   // Request decode
   assign w_req      = wb.wb_cyc_i & wb.wb_stb_i;
   assign w_hit      = w_req & (wb.wb_adr_i[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);
   assign w_waddr    = wb.wb_adr_i[TAG_LO-1:OFF_W];
   assign w_cti_inc  = (wb.wb_cti_i == 3'b010);
   assign w_cti_end  = (wb.wb_cti_i == 3'b111);
   // Oldest issued read has its data on ram_rdata this cycle
   assign w_rd_valid = r_pipe[RD_LAT-1];
   assign w_unused   = ^wb.wb_adr_i[OFF_W-1:0];

   // State register
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (!w_hit)            w_state_nxt = S_ERR;
               else if (wb.wb_we_i)   w_state_nxt = w_cti_inc ? S_WBURST : S_WACK;
               else                   w_state_nxt = w_cti_inc ? S_RBURST : S_RWAIT;
            end
         end
         S_WACK, S_RACK, S_ERR: w_state_nxt = S_IDLE;
         S_RWAIT: begin
            if (!w_req)          w_state_nxt = S_IDLE;
            else if (w_rd_valid) w_state_nxt = S_RACK;
         end
         S_WBURST: if (!w_req || w_cti_end) w_state_nxt = S_IDLE;
         S_RBURST: if (!w_req || (r_ack && w_cti_end)) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // RAM strobes and next values of the registered bus outputs / read pipeline
   always_comb begin
      ram_en     = 1'b0;
      ram_we     = '0;
      ram_addr   = w_waddr;
      w_ack_nxt  = 1'b0;
      w_err_nxt  = 1'b0;
      w_issue    = 1'b0;
      w_flush    = 1'b0;
      w_capture  = 1'b0;
      w_addr_nxt = r_addr;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (!w_hit) begin
                  w_err_nxt = 1'b1;
               end else if (wb.wb_we_i) begin
                  ram_en    = 1'b1;
                  ram_we    = wb.wb_sel_i;
                  w_ack_nxt = 1'b1;
               end else begin
                  ram_en     = 1'b1;
                  w_issue    = 1'b1;
                  w_addr_nxt = w_waddr + ADDR_W'(1);
               end
            end
         end
         S_RWAIT: begin
            if (!w_req) begin
               w_flush = 1'b1;
            end else if (w_rd_valid) begin
               w_ack_nxt = 1'b1;
               w_capture = 1'b1;
            end
         end
         S_WBURST: begin
            // Ack stays high while the burst continues; the bus address of each beat is used
            if (w_req && wb.wb_we_i) begin
               ram_en = 1'b1;
               ram_we = wb.wb_sel_i;
            end
            w_ack_nxt = w_req & ~w_cti_end;
         end
         S_RBURST: begin
            // Prefetch one word per cycle; anything still in flight at the end is dropped
            if (!w_req || (r_ack && w_cti_end)) begin
               w_flush = 1'b1;
            end else begin
               ram_en     = 1'b1;
               ram_addr   = r_addr;
               w_issue    = 1'b1;
               w_addr_nxt = r_addr + ADDR_W'(1);
               w_ack_nxt  = w_rd_valid;
               w_capture  = w_rd_valid;
            end
         end
         default: w_flush = 1'b1;
      endcase
      if (!wb_rst_i) begin
         ram_en = 1'b0;
         ram_we = '0;
      end
   end

   // Registered bus outputs, burst address and read-valid pipeline
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_ack  <= 1'b0;
         r_err  <= 1'b0;
         r_dat  <= '0;
         r_addr <= '0;
         r_pipe <= '0;
      end else begin
         r_ack  <= w_ack_nxt;
         r_err  <= w_err_nxt;
         r_addr <= w_addr_nxt;
         if (w_capture) r_dat <= ram_rdata;
         if (w_flush)   r_pipe <= '0;
         else           r_pipe <= RD_LAT'({r_pipe, w_issue});
      end
   end

   // Qualify with the live request so an abandoned transfer never shows a late ack/err
   assign wb.wb_ack_o = r_ack & w_req;
   assign wb.wb_err_o = r_err & w_req;
   assign wb.wb_dat_o = r_dat;
   assign ram_wdata   = wb.wb_dat_i;
endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Randomized self-checking bench for wb_bram_ctrl against a word-array reference model.
module tb_wb_bram_ctrl;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam logic [31:0] BASE   = 32'h1000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_bram_ctrl_if #(.DATA_W(DATA_W)) wb ();

   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] shadow [DEPTH];

   wb_bram_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .BASE_ADDR(BASE)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .wb       (wb),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // Block RAM with RD_LAT-cycle read latency; cleared while reset is low
   logic [31:0] mem  [DEPTH];
   logic [31:0] rd_q [RD_LAT];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         for (int i = 0; i < int'(RD_LAT); i++) rd_q[i] <= '0;
      end else begin
         if (ram_en) begin
            for (int b = 0; b < 4; b++)
               if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            rd_q[0] <= mem[ram_addr];
         end
         for (int i = 1; i < int'(RD_LAT); i++) rd_q[i] <= rd_q[i-1];
      end
   end
   assign ram_rdata = rd_q[RD_LAT-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic cyc, input logic we, input logic [ADDR_W-1:0] wa,
                        input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti);
      wb.wb_cyc_i = cyc;
      wb.wb_stb_i = cyc;
      wb.wb_we_i  = we;
      wb.wb_adr_i = BASE | 32'({wa, 2'b00});
      wb.wb_dat_i = dat;
      wb.wb_sel_i = sel;
      wb.wb_cti_i = cti;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, '0, 3'b000);
   endtask

   task automatic shadow_write(input logic [ADDR_W-1:0] wa, input logic [31:0] d, input logic [3:0] sel);
      for (int b = 0; b < 4; b++)
         if (sel[b]) shadow[wa][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic wr(input logic [ADDR_W-1:0] wa, input logic [31:0] d, input logic [3:0] sel);
      @(posedge clk); #1; drive(1'b1, 1'b1, wa, d, sel, 3'b000);
      @(negedge clk);
      chk("wr_en",   64'(ram_en),    64'(1));
      chk("wr_we",   64'(ram_we),    64'(sel));
      chk("wr_addr", 64'(ram_addr),  64'(wa));
      chk("wr_data", 64'(ram_wdata), 64'(d));
      @(posedge clk); #1;
      @(negedge clk);
      chk("wr_ack",  64'(wb.wb_ack_o), 64'(1));
      chk("wr_once", 64'(ram_we),      64'(0));
      @(posedge clk); #1; idle();
      @(negedge clk);
      chk("wr_ack_clr", 64'(wb.wb_ack_o), 64'(0));
      shadow_write(wa, d, sel);
   endtask

   task automatic rd(input logic [ADDR_W-1:0] wa);
      int c = 0;
      bit got = 1'b0;
      @(posedge clk); #1; drive(1'b1, 1'b0, wa, '0, 4'hF, 3'b000);
      @(negedge clk);
      chk("rd_en",   64'(ram_en),   64'(1));
      chk("rd_we",   64'(ram_we),   64'(0));
      chk("rd_addr", 64'(ram_addr), 64'(wa));
      while (!got && c < int'(RD_LAT) + 6) begin
         @(posedge clk); #1; c++;
         @(negedge clk);
         if (wb.wb_ack_o === 1'b1) got = 1'b1;
      end
      chk("rd_latency", 64'(c), 64'(RD_LAT + 1));
      chk("rd_data", 64'(wb.wb_dat_o), 64'(shadow[wa]));
      @(posedge clk); #1; idle();
      @(negedge clk);
      chk("rd_ack_clr", 64'(wb.wb_ack_o), 64'(0));
   endtask

   // Incrementing read burst of nb beats; master walks away after 'stop' acks
   task automatic rburst(input logic [ADDR_W-1:0] wa, input int nb, input int stop);
      int acks = 0;
      int c = 0;
      logic [ADDR_W-1:0] ea;
      @(posedge clk); #1; drive(1'b1, 1'b0, wa, '0, 4'hF, (nb == 1) ? 3'b111 : 3'b010);
      while (acks < stop && c < nb + int'(RD_LAT) + 6) begin
         @(negedge clk);
         if (wb.wb_ack_o === 1'b1) begin
            ea = ADDR_W'(int'(wa) + acks);
            chk("rb_cycle", 64'(c), 64'(int'(RD_LAT) + 1 + acks));
            chk("rb_data", 64'(wb.wb_dat_o), 64'(shadow[ea]));
            acks++;
         end
         @(posedge clk); #1; c++;
         if (acks >= stop) idle();
         else drive(1'b1, 1'b0, ADDR_W'(int'(wa) + acks), '0, 4'hF,
                    (acks == nb - 1) ? 3'b111 : 3'b010);
      end
      idle();
      chk("rb_beats", 64'(acks), 64'(stop));
      @(negedge clk);
      chk("rb_tail_ack", 64'(wb.wb_ack_o), 64'(0));
      chk("rb_tail_en",  64'(ram_en),      64'(0));
   endtask

   // Incrementing write burst; a beat advances on every ack
   task automatic wburst(input logic [ADDR_W-1:0] wa, input int nb);
      int j = 0;
      int c = 0;
      logic [31:0] d [8];
      for (int k = 0; k < 8; k++) d[k] = $urandom;
      @(posedge clk); #1; drive(1'b1, 1'b1, wa, d[0], 4'hF, (nb == 1) ? 3'b111 : 3'b010);
      while (j < nb && c < nb + 6) begin
         @(negedge clk);
         if (wb.wb_ack_o === 1'b1) begin
            chk("wb_cycle", 64'(c), 64'(j + 1));
            shadow_write(ADDR_W'(int'(wa) + j), d[j], 4'hF);
            j++;
         end
         @(posedge clk); #1; c++;
         if (j >= nb) idle();
         else drive(1'b1, 1'b1, ADDR_W'(int'(wa) + j), d[j], 4'hF,
                    (j == nb - 1) ? 3'b111 : 3'b010);
      end
      idle();
      chk("wb_beats", 64'(j), 64'(nb));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [ADDR_W-1:0] wa;
      int nb;
      int seen;
      idle();
      for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;

      // Reset state, with a request held on the bus while reset is low
      repeat (2) @(posedge clk);
      #1; drive(1'b1, 1'b0, 12'h004, '0, 4'hF, 3'b000);
      @(negedge clk);
      chk("rst_ack",    64'(wb.wb_ack_o), 64'(0));
      chk("rst_err",    64'(wb.wb_err_o), 64'(0));
      chk("rst_dat",    64'(wb.wb_dat_o), 64'(0));
      chk("rst_ram_en", 64'(ram_en),      64'(0));
      chk("rst_ram_we", 64'(ram_we),      64'(0));
      idle();
      @(negedge clk); rst_n = 1'b1;

      // Classic write then classic read of the same word
      wr(12'h004, 32'hDEAD_BEEF, 4'b1100);
      rd(12'h004);
      chk("rd_hi_half", 64'(wb.wb_dat_o[31:16]), 64'(16'hDEAD));

      // Four-beat read burst across the top of the region
      wr(12'hFFE, 32'h1111_0FFE, 4'hF);
      wr(12'hFFF, 32'h2222_0FFF, 4'hF);
      wr(12'h000, 32'h3333_0000, 4'hF);
      wr(12'h001, 32'h4444_0001, 4'hF);
      rburst(12'hFFE, 4, 4);
      rd(12'h002);

      // Out-of-region access
      @(posedge clk); #1; drive(1'b1, 1'b0, '0, '0, 4'hF, 3'b000);
      wb.wb_adr_i = 32'h2000_0000;
      @(negedge clk);
      chk("err_en_n",  64'(ram_en),      64'(0));
      chk("err_n",     64'(wb.wb_err_o), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_n1",    64'(wb.wb_err_o), 64'(1));
      chk("err_ack",   64'(wb.wb_ack_o), 64'(0));
      chk("err_en_n1", 64'(ram_en),      64'(0));
      @(posedge clk); #1; idle();
      @(negedge clk);
      chk("err_clr",   64'(wb.wb_err_o), 64'(0));

      // Strobe dropped mid read burst after two acks
      rburst(12'hFFE, 6, 2);
      rd(12'hFFF);

      // Randomized mix of transfers
      for (int it = 0; it < 60; it++) begin
         wa = ADDR_W'($urandom);
         if ($urandom_range(0, 3) == 0) wa = ADDR_W'(DEPTH - 1 - $urandom_range(0, 2));
         case ($urandom_range(0, 3))
            0: wr(wa, $urandom, 4'($urandom_range(1, 15)));
            1: rd(wa);
            2: begin
               nb = $urandom_range(1, 5);
               rburst(wa, nb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb) : nb);
            end
            default: wburst(wa, $urandom_range(1, 4));
         endcase
      end

      // Reset while a classic read is waiting on RAM data
      wr(12'h005, 32'hA5A5_5A5A, 4'hF);
      rd(12'h005);
      @(posedge clk); #1; drive(1'b1, 1'b0, 12'h005, '0, 4'hF, 3'b000);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("rrst_ack", 64'(wb.wb_ack_o), 64'(0));
      chk("rrst_err", 64'(wb.wb_err_o), 64'(0));
      chk("rrst_dat", 64'(wb.wb_dat_o), 64'(0));
      chk("rrst_en",  64'(ram_en),      64'(0));
      @(posedge clk); #1; idle();
      for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (wb.wb_ack_o === 1'b1) seen++;
      end
      chk("rrst_no_ack", 64'(seen), 64'(0));
      wr(12'h006, 32'h0BAD_F00D, 4'hF);
      rd(12'h006);
      rd(12'h005);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
